sd_resp_regfile: RTL and testbench

Multi-slot SD card register file that captures command responses bit-serially from the CMD line and commits them into per-card CID/CSD/OCR/RCA/STATUS registers. It is the successor to the fixed single-card register set: the slot count is parametrised, responses load directly from the wire with CRC7, index and framing checks, and a host write port remains for direct loads. It sits between the CMD-line bit sampler and the host controller's command engine.

---
 rtl/sd_resp_regfile.sv | 247 ++++++++++++++++++++++++
 tb/tb_sd_resp_regfile.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_resp_regfile.sv
// rtl/sd_resp_regfile.sv - multi-slot SD card register file with bit-serial CMD response capture
module sd_resp_regfile #(
  parameter int SLOT_W  = 2,
  parameter int NCR_MAX = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        resp_type,
  input  logic [5:0]        cmd_idx,
  input  logic [SLOT_W-1:0] slot,
  input  logic              cmd_bit,
  input  logic              cmd_bit_valid,
  input  logic              wr_en,
  input  logic [SLOT_W-1:0] wr_slot,
  input  logic [2:0]        wr_sel,
  input  logic [127:0]      wr_data,
  input  logic [SLOT_W-1:0] rd_slot,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err,
  output logic [127:0]      cid_out,
  output logic [127:0]      csd_out,
  output logic [31:0]       ocr_out,
  output logic [63:0]       stat_out,
  output logic [15:0]       rca_out,
  output logic [15:0]       dsr_out
);
  localparam int NSLOT  = 1 << SLOT_W;
  localparam int WAIT_W = $clog2(NCR_MAX);

  localparam logic [2:0] T_R1 = 3'd1, T_CID = 3'd2, T_CSD = 3'd3, T_R3 = 3'd4, T_R6 = 3'd5;
  localparam logic [1:0] E_OK = 2'd0, E_TMO = 2'd1, E_CRC = 2'd2, E_FRM = 2'd3;
  localparam logic [127:0] CSD_RST = {24'h0, 8'h32, 96'h0};

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RECV} state_t;

  state_t              state_q, state_d;
  logic [2:0]          type_q, type_d;
  logic [5:0]          idx_q, idx_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [7:0]          bit_cnt_q, bit_cnt_d;
  logic [134:0]        sh_q, sh_d;
  logic [6:0]          crc_q, crc_d;
  logic                done_q, done_d;
  logic [1:0]          err_q, err_d;

  logic [127:0] cid_q  [NSLOT];
  logic [127:0] cid_d  [NSLOT];
  logic [127:0] csd_q  [NSLOT];
  logic [127:0] csd_d  [NSLOT];
  logic [31:0]  ocr_q  [NSLOT];
  logic [31:0]  ocr_d  [NSLOT];
  logic [15:0]  rca_q  [NSLOT];
  logic [15:0]  rca_d  [NSLOT];
  logic [15:0]  dsr_q  [NSLOT];
  logic [15:0]  dsr_d  [NSLOT];
  logic [37:0]  stat_q [NSLOT];
  logic [37:0]  stat_d [NSLOT];

  logic         is_r2;
  logic [7:0]   frame_len;
  logic [7:0]   pos;
  logic         last_bit;
  logic         crc_feed;
  logic [6:0]   crc_next;
  logic [135:0] full;
  logic [47:0]  f48;
  logic [31:0]  payload;
  logic         frm_bad;
  logic         crc_bad;
  logic [37:0]  r6_stat;

  always_comb begin
    is_r2     = (type_q == T_CID) || (type_q == T_CSD);
    frame_len = is_r2 ? 8'd136 : 8'd48;
    pos       = frame_len - 8'd1 - bit_cnt_q;
    last_bit  = (bit_cnt_q == frame_len - 8'd1);
    // R2 CRC covers only the register field, so the 8 header bits are skipped
    crc_feed  = (pos >= 8'd8) && (!is_r2 || pos <= 8'd127);
    crc_next  = {crc_q[5:0], 1'b0} ^ ({7{cmd_bit ^ crc_q[6]}} & 7'h09);
    full      = {sh_q, cmd_bit};
    f48       = full[47:0];
    payload   = f48[39:8];

    if (is_r2) begin
      frm_bad = full[135] | full[134] | (full[133:128] != 6'h3F) | !full[0];
      crc_bad = (crc_q != full[7:1]);
    end else begin
      frm_bad = f48[47] | f48[46] | !f48[0] |
                ((type_q == T_R3) ? (f48[45:40] != 6'h3F) : (f48[45:40] != idx_q));
      crc_bad = (type_q != T_R3) && (crc_q != f48[7:1]);
    end

    r6_stat        = '0;
    r6_stat[37:32] = f48[45:40];
    r6_stat[23:22] = payload[15:14];
    r6_stat[19]    = payload[13];
    r6_stat[12:0]  = payload[12:0];
  end

  always_comb begin
    state_d    = state_q;
    type_d     = type_q;
    idx_d      = idx_q;
    slot_d     = slot_q;
    wait_cnt_d = wait_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    sh_d       = sh_q;
    crc_d      = crc_q;
    done_d     = 1'b0;
    err_d      = err_q;
    cid_d      = cid_q;
    csd_d      = csd_q;
    ocr_d      = ocr_q;
    rca_d      = rca_q;
    dsr_d      = dsr_q;
    stat_d     = stat_q;

    // Host write goes first so a same-cycle commit below overrides it
    if (wr_en) begin
      case (wr_sel)
        3'd0:    cid_d[wr_slot]  = wr_data;
        3'd1:    csd_d[wr_slot]  = wr_data;
        3'd2:    ocr_d[wr_slot]  = wr_data[31:0];
        3'd3:    rca_d[wr_slot]  = wr_data[15:0];
        3'd4:    stat_d[wr_slot] = wr_data[37:0];
        3'd5:    dsr_d[wr_slot]  = wr_data[15:0];
        default: ;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d = E_OK;
          if (resp_type >= T_R1 && resp_type <= T_R6) begin
            type_d     = resp_type;
            idx_d      = cmd_idx;
            slot_d     = slot;
            wait_cnt_d = '0;
            state_d    = S_WAIT;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (cmd_bit_valid) begin
          if (!cmd_bit) begin
            state_d   = S_RECV;
            bit_cnt_d = 8'd1;
            crc_d     = '0;
            sh_d      = '0;
          end else if (wait_cnt_q == WAIT_W'(NCR_MAX - 1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            err_d   = E_TMO;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end
      end
      S_RECV: begin
        if (cmd_bit_valid) begin
          sh_d      = full[134:0];
          bit_cnt_d = bit_cnt_q + 8'd1;
          if (crc_feed) crc_d = crc_next;
          if (last_bit) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            err_d   = frm_bad ? E_FRM : (crc_bad ? E_CRC : E_OK);
            if (!frm_bad && !crc_bad) begin
              case (type_q)
                T_R1:    stat_d[slot_q] = {f48[45:40], payload};
                T_R6: begin
                  rca_d[slot_q]  = payload[31:16];
                  stat_d[slot_q] = r6_stat;
                end
                T_R3: begin
                  ocr_d[slot_q]         = payload;
                  stat_d[slot_q][37:32] = 6'h3F;
                end
                T_CID:   cid_d[slot_q] = {full[127:1], 1'b1};
                T_CSD:   csd_d[slot_q] = {full[127:1], 1'b1};
                default: ;
              endcase
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      type_q     <= '0;
      idx_q      <= '0;
      slot_q     <= '0;
      wait_cnt_q <= '0;
      bit_cnt_q  <= '0;
      sh_q       <= '0;
      crc_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= E_OK;
      for (int i = 0; i < NSLOT; i++) begin
        cid_q[i]  <= '0;
        csd_q[i]  <= CSD_RST;
        ocr_q[i]  <= 32'h0060_0000;
        rca_q[i]  <= '0;
        dsr_q[i]  <= 16'h0404;
        stat_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      type_q     <= type_d;
      idx_q      <= idx_d;
      slot_q     <= slot_d;
      wait_cnt_q <= wait_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      sh_q       <= sh_d;
      crc_q      <= crc_d;
      done_q     <= done_d;
      err_q      <= err_d;
      cid_q      <= cid_d;
      csd_q      <= csd_d;
      ocr_q      <= ocr_d;
      rca_q      <= rca_d;
      dsr_q      <= dsr_d;
      stat_q     <= stat_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign err      = err_q;
  assign cid_out  = cid_q[rd_slot];
  assign csd_out  = csd_q[rd_slot];
  assign ocr_out  = ocr_q[rd_slot];
  assign rca_out  = rca_q[rd_slot];
  assign dsr_out  = dsr_q[rd_slot];
  assign stat_out = {26'd0, stat_q[rd_slot]};

endmodule

// File: tb/tb_sd_resp_regfile.sv
// tb/tb_sd_resp_regfile.sv - scoreboard bench for sd_resp_regfile
module tb_sd_resp_regfile;
  localparam int SLOT_W = 2;
  localparam int NS     = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [2:0]        resp_type;
  logic [5:0]        cmd_idx;
  logic [SLOT_W-1:0] slot;
  logic              cmd_bit;
  logic              cmd_bit_valid;
  logic              wr_en;
  logic [SLOT_W-1:0] wr_slot;
  logic [2:0]        wr_sel;
  logic [127:0]      wr_data;
  logic [SLOT_W-1:0] rd_slot;
  logic              busy;
  logic              done;
  logic [1:0]        err;
  logic [127:0]      cid_out;
  logic [127:0]      csd_out;
  logic [31:0]       ocr_out;
  logic [63:0]       stat_out;
  logic [15:0]       rca_out;
  logic [15:0]       dsr_out;

  sd_resp_regfile #(.SLOT_W(SLOT_W), .NCR_MAX(64)) dut (
    .clk(clk), .reset(reset), .start(start), .resp_type(resp_type), .cmd_idx(cmd_idx),
    .slot(slot), .cmd_bit(cmd_bit), .cmd_bit_valid(cmd_bit_valid), .wr_en(wr_en),
    .wr_slot(wr_slot), .wr_sel(wr_sel), .wr_data(wr_data), .rd_slot(rd_slot),
    .busy(busy), .done(done), .err(err), .cid_out(cid_out), .csd_out(csd_out),
    .ocr_out(ocr_out), .stat_out(stat_out), .rca_out(rca_out), .dsr_out(dsr_out)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  int n_done = 0;
  logic [1:0] exp_q[$];

  logic [127:0] m_cid  [NS];
  logic [127:0] m_csd  [NS];
  logic [31:0]  m_ocr  [NS];
  logic [15:0]  m_rca  [NS];
  logic [15:0]  m_dsr  [NS];
  logic [63:0]  m_stat [NS];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0 && done === 1'b1) begin
      n_done++;
      if (exp_q.size() == 0) chk("done_unexpected", done, 0);
      else chk("err_on_done", err, exp_q.pop_front());
    end
  end

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      m_cid[s]  = '0;
      m_csd[s]  = 128'h0000_0032 << 96;
      m_ocr[s]  = 32'h0060_0000;
      m_rca[s]  = '0;
      m_dsr[s]  = 16'h0404;
      m_stat[s] = '0;
    end
  endtask

  task automatic model_commit(input logic [2:0] t, input int s, input logic [135:0] f);
    logic [31:0] p;
    p = f[39:8];
    case (t)
      3'd1: m_stat[s] = {26'd0, f[45:40], p};
      3'd5: begin
        m_rca[s]  = p[31:16];
        m_stat[s] = {26'd0, f[45:40], 8'd0, p[15:14], 2'd0, p[13], 6'd0, p[12:0]};
      end
      3'd4: begin
        m_ocr[s]         = p;
        m_stat[s][37:32] = 6'h3F;
      end
      3'd2: m_cid[s] = {f[127:1], 1'b1};
      3'd3: m_csd[s] = {f[127:1], 1'b1};
      default: ;
    endcase
  endtask

  task automatic check_all();
    for (int s = 0; s < NS; s++) begin
      rd_slot = SLOT_W'(s);
      #1;
      chk($sformatf("cid[%0d]", s),  cid_out,  m_cid[s]);
      chk($sformatf("csd[%0d]", s),  csd_out,  m_csd[s]);
      chk($sformatf("ocr[%0d]", s),  ocr_out,  m_ocr[s]);
      chk($sformatf("rca[%0d]", s),  rca_out,  m_rca[s]);
      chk($sformatf("dsr[%0d]", s),  dsr_out,  m_dsr[s]);
      chk($sformatf("stat[%0d]", s), stat_out, m_stat[s]);
    end
  endtask

  // CRC7 by polynomial long division of M(x)*x^7 by x^7+x^3+1
  function automatic logic [6:0] crc7(input logic [119:0] m, input int n);
    logic [126:0] r;
    r = {m, 7'b0};
    for (int i = n + 6; i >= 7; i--)
      if (r[i]) r[i-:8] = r[i-:8] ^ 8'h89;
    return r[6:0];
  endfunction

  function automatic logic [135:0] mk48(input logic [5:0] ix, input logic [31:0] p);
    logic [39:0] m;
    m = {2'b00, ix, p};
    return {88'd0, m, crc7(120'(m), 40), 1'b1};
  endfunction

  function automatic logic [135:0] mk136(input logic [119:0] c);
    return {2'b00, 6'h3F, c, crc7(c, 120), 1'b1};
  endfunction

  task automatic drive(input logic b, input bit gaps, input bit hw);
    if (gaps) begin
      while ($urandom_range(0, 2) == 0) begin
        cmd_bit_valid = 1'b0;
        cmd_bit       = 1'($urandom);
        @(negedge clk);
      end
    end
    cmd_bit       = b;
    cmd_bit_valid = 1'b1;
    wr_en         = hw;
    @(negedge clk);
    cmd_bit_valid = 1'b0;
    wr_en         = 1'b0;
    start         = 1'b0;
  endtask

  task automatic capture(input logic [2:0] typ, input logic [5:0] cidx, input int sl,
                         input logic [135:0] fr, input int len, input int pre,
                         input logic [1:0] e, input bit gaps, input bit collide, input bit poke);
    int base;
    int total;
    logic b;
    base = n_done;
    total = pre + len;
    @(negedge clk);
    start     = 1'b1;
    resp_type = typ;
    cmd_idx   = cidx;
    slot      = SLOT_W'(sl);
    exp_q.push_back(e);
    @(negedge clk);
    start     = 1'b0;
    resp_type = 3'($urandom);
    cmd_idx   = 6'($urandom);
    slot      = SLOT_W'($urandom);
    chk("busy_after_start", busy, (typ >= 3'd1 && typ <= 3'd5));
    wr_slot = SLOT_W'(sl);
    wr_sel  = 3'd0;
    wr_data = {$urandom, $urandom, $urandom, $urandom};
    for (int k = 0; k < total; k++) begin
      b = (k < pre) ? 1'b1 : fr[total - 1 - k];
      if (k == total - 1) chk("no_early_done", n_done - base, 0);
      if (poke && k == pre + 10) begin
        start     = 1'b1;
        resp_type = 3'd1;
        slot      = SLOT_W'(sl + 1);
      end
      drive(b, gaps, collide && (k == total - 1));
    end
    for (int k = 0; k < 4 && n_done == base; k++) @(negedge clk);
    @(negedge clk);
    chk("done_pulses", n_done - base, 1);
    chk("busy_after_done", busy, 0);
    chk("err_held", err, e);
    if (e == 2'd0) model_commit(typ, sl, fr);
    check_all();
  endtask

  task automatic hwrite(input logic [2:0] sel, input int sl, input logic [127:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_sel = sel; wr_slot = SLOT_W'(sl); wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    case (sel)
      3'd0: m_cid[sl]  = d;
      3'd1: m_csd[sl]  = d;
      3'd2: m_ocr[sl]  = d[31:0];
      3'd3: m_rca[sl]  = d[15:0];
      3'd4: m_stat[sl] = {26'd0, d[37:0]};
      3'd5: m_dsr[sl]  = d[15:0];
      default: ;
    endcase
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [135:0] fr;
    logic [127:0] rnd;
    reset = 1'b1; start = 1'b0; resp_type = '0; cmd_idx = '0; slot = '0;
    cmd_bit = 1'b1; cmd_bit_valid = 1'b0; wr_en = 1'b0; wr_slot = '0; wr_sel = '0;
    wr_data = '0; rd_slot = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    check_all();
    reset = 1'b0;

    capture(3'd0, 6'd0, 0, '0, 0, 0, 2'd0, 0, 0, 0);
    capture(3'd7, 6'd0, 1, '0, 0, 0, 2'd0, 0, 0, 0);

    fr = 136'(48'h11_0000_0900_65);
    capture(3'd1, 6'd17, 2, fr, 48, 3, 2'd2, 0, 0, 0);
    fr = 136'(48'h11_0000_0900_67);
    capture(3'd1, 6'd16, 2, fr, 48, 3, 2'd3, 0, 0, 0);
    fr = 136'(48'h11_0000_0900_66);
    capture(3'd1, 6'd17, 2, fr, 48, 3, 2'd3, 0, 0, 0);
    fr = 136'(48'h11_0000_0900_67);
    capture(3'd1, 6'd17, 2, fr, 48, 3, 2'd0, 0, 0, 1);

    fr = 136'(48'h3F_80FF_8000_FF);
    capture(3'd4, 6'd41, 0, fr, 48, 5, 2'd0, 0, 0, 0);

    fr = mk48(6'd3, 32'hAAAA_E500);
    capture(3'd5, 6'd3, 1, fr, 48, 1, 2'd0, 1, 0, 0);
    capture(3'd5, 6'd3, 1, '0, 0, 64, 2'd1, 0, 0, 0);

    hwrite(3'd5, 1, 128'h1234);
    hwrite(3'd2, 2, 128'hDEAD_BEEF);
    hwrite(3'd4, 0, 128'h2A_1234_5678);
    hwrite(3'd6, 3, 128'hFFFF);
    check_all();

    rnd = {$urandom, $urandom, $urandom, $urandom};
    fr = mk136(rnd[119:0]);
    capture(3'd2, 6'd2, 3, fr, 136, 2, 2'd0, 1, 1, 0);
    rnd = {$urandom, $urandom, $urandom, $urandom};
    fr = mk136(rnd[119:0]);
    capture(3'd3, 6'd9, 0, fr, 136, 0, 2'd0, 1, 0, 0);

    rnd = {$urandom, $urandom, $urandom, $urandom};
    fr = mk136(rnd[119:0]);
    @(negedge clk);
    start = 1'b1; resp_type = 3'd3; slot = SLOT_W'(1);
    @(negedge clk);
    start = 1'b0;
    for (int k = 135; k > 85; k--) drive(fr[k], 0, 0);
    #2;
    reset = 1'b1;
    #1;
    chk("midreset_busy", busy, 0);
    chk("midreset_done", done, 0);
    chk("midreset_err", err, 0);
    model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_reset_done_count", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
